// File: rtl/kgd_vram_arb.sv
// Video RAM arbiter: a Wishbone classic CPU port and a video-refresh fetch port share one single-port VRAM.
// Optional macro KGD_ARB_STARVE_EN bounds consecutive video grants while a CPU request waits.
module kgd_vram_arb #(
    parameter int VID_BURST_MAX = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [13:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    input  logic [1:0]  wb_sel_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        vid_req_i,
    input  logic [13:0] vid_adr_i,
    output logic        vid_gnt_o,
    output logic        vid_valid_o,
    output logic [7:0]  vid_dat_o,
    output logic [13:0] ram_adr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_d_o,
    input  logic [7:0]  ram_q_i,
    output logic [1:0]  cpu_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } cpu_state_t;

    cpu_state_t state, state_nxt;
    logic       write_q;
    logic       cpu_pending;
    logic       cpu_win;
    logic       vid_win;
    logic       vid_gnt_q;
    logic       unused_bits;

    assign unused_bits = ^{wb_dat_i[15:8], wb_sel_i[1]};

    // Handshakes: a CPU request is accepted in the cycle it wins (the FSM leaves IDLE) and
    // completes on the single-cycle wb_ack_o; a video request is accepted in any cycle where
    // vid_gnt_o=1, and its data appears with vid_valid_o exactly two cycles later.
    assign cpu_pending = wb_cyc_i & wb_stb_i & (state == ST_IDLE) & ~wb_ack_o;

`ifdef KGD_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = (starve_cnt == 4'(VID_BURST_MAX));
    assign cpu_win    = cpu_pending & (~vid_req_i | starve_hit);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            starve_cnt <= 4'd0;
        end else if (cpu_win || !cpu_pending) begin
            starve_cnt <= 4'd0;
        end else if (vid_win) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign cpu_win = cpu_pending & ~vid_req_i;
`endif

    assign vid_win   = wb_rst_n_i & vid_req_i & ~cpu_win;
    assign vid_gnt_o = vid_win;
    assign wb_ack_o  = (state == ST_ACK);
    assign vid_dat_o = ram_q_i;
    assign cpu_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cpu_win) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = write_q ? ST_ACK : ST_WAIT;
            ST_WAIT:  state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The sequence never looks at wb_cyc_i after the grant, so a dropped cycle still completes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= ST_IDLE;
            write_q  <= 1'b0;
            wb_dat_o <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (cpu_win) write_q <= wb_we_i;
            if (state == ST_WAIT) wb_dat_o <= {8'h00, ram_q_i};
        end
    end

    // The slot: RAM controls for the winner of the previous cycle; address holds between slots.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ram_adr_o <= 14'h0000;
            ram_we_o  <= 1'b0;
            ram_d_o   <= 8'h00;
        end else if (cpu_win) begin
            ram_adr_o <= wb_adr_i;
            ram_we_o  <= wb_we_i & wb_sel_i[0];
            if (wb_we_i) ram_d_o <= wb_dat_i[7:0];
        end else if (vid_win) begin
            ram_adr_o <= vid_adr_i;
            ram_we_o  <= 1'b0;
        end else begin
            ram_we_o  <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            vid_gnt_q   <= 1'b0;
            vid_valid_o <= 1'b0;
        end else begin
            vid_gnt_q   <= vid_win;
            vid_valid_o <= vid_gnt_q;
        end
    end

endmodule

// File: tb/tb_kgd_vram_arb.sv
// Bench for kgd_vram_arb: VRAM fixture, cycle-scheduled reference model and directed scenarios.
// Follows the DUT build: define KGD_ARB_STARVE_EN for both to exercise the starvation limit.
`timescale 1ns/1ps
module tb_kgd_vram_arb;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [13:0] wb_adr = '0;
    logic [15:0] wb_dat = '0;
    logic [1:0]  wb_sel = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack;
    logic        vid_req = 1'b0;
    logic [13:0] vid_adr = '0;
    logic        vid_gnt, vid_valid;
    logic [7:0]  vid_dat;
    logic [13:0] ram_adr;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = 8'h00;
    logic [1:0]  cpu_state;

    always #5 clk = ~clk;

    kgd_vram_arb #(.VID_BURST_MAX(BURST)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack),
        .vid_req_i(vid_req), .vid_adr_i(vid_adr),
        .vid_gnt_o(vid_gnt), .vid_valid_o(vid_valid), .vid_dat_o(vid_dat),
        .ram_adr_o(ram_adr), .ram_we_o(ram_we), .ram_d_o(ram_d), .ram_q_i(ram_q),
        .cpu_state(cpu_state)
    );

    function automatic logic [7:0] pat(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    // VRAM fixture: preset contents pat(a), one-cycle registered read, read-before-write.
    logic [7:0] fx_mem [0:16383];
    bit         fx_wv  [0:16383];

    function automatic logic [7:0] fx_rd(input logic [13:0] a);
        return fx_wv[a] ? fx_mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        ram_q <= fx_rd(ram_adr);
        if (ram_we) begin
            fx_mem[ram_adr] <= ram_d;
            fx_wv[ram_adr]  <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-cycle arbitration rules, expected events scheduled by absolute cycle.
    int          cyc = 0;
    int          busy_until = -1;
    int          vcnt = 0;
    logic [13:0] last_adr = '0;
    logic [13:0] e_slot [int];
    bit          e_we [int];
    logic [7:0]  e_d [int];
    logic [7:0]  e_vdat [int];
    int          e_ack [int];
    logic [7:0]  mm [int];
    logic [15:0] exp_q [$];

    function automatic logic [7:0] mread(input logic [13:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : pat(a);
    endfunction

    always @(negedge clk) begin : model
        bit pend, cpu, vg;
        int c;
        c = cyc;
        if (!rst_n) begin
            e_slot.delete(); e_we.delete(); e_d.delete(); e_vdat.delete(); e_ack.delete();
            exp_q.delete();
            busy_until = c; vcnt = 0; last_adr = '0;
            chk("rst_vid_gnt", vid_gnt, 0);
            chk("rst_wb_ack", wb_ack, 0);
            chk("rst_wb_dat", wb_dat_o, 0);
            chk("rst_vid_valid", vid_valid, 0);
            chk("rst_vid_dat", vid_dat, ram_q);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_adr", ram_adr, 0);
            chk("rst_ram_d", ram_d, 0);
            chk("rst_state", cpu_state, 0);
        end else begin
            if (e_slot.exists(c)) last_adr = e_slot[c];
            chk("ram_adr", ram_adr, last_adr);
            chk("ram_we", ram_we, e_we.exists(c) ? e_we[c] : 1'b0);
            if (e_we.exists(c) && e_we[c]) chk("ram_d", ram_d, e_d[c]);
            chk("vid_valid", vid_valid, e_vdat.exists(c));
            if (e_vdat.exists(c)) chk("vid_dat", vid_dat, e_vdat[c]);
            chk("wb_ack", wb_ack, e_ack.exists(c));
            if (e_ack.exists(c) && e_ack[c] == 2 && exp_q.size() > 0)
                chk("wb_dat", wb_dat_o, exp_q.pop_front());

            pend = wb_cyc && wb_stb && (c > busy_until);
`ifdef KGD_ARB_STARVE_EN
            cpu = pend && (!vid_req || vcnt == BURST);
`else
            cpu = pend && !vid_req;
`endif
            vg = vid_req && !cpu;
            chk("vid_gnt", vid_gnt, vg);
            if (!pend || cpu) vcnt = 0;
            else if (vg) vcnt++;

            if (cpu) begin
                e_slot[c+1] = wb_adr;
                if (wb_we) begin
                    e_we[c+1] = wb_sel[0];
                    e_d[c+1]  = wb_dat[7:0];
                    if (wb_sel[0]) mm[int'(wb_adr)] = wb_dat[7:0];
                    e_ack[c+2] = 1;
                    busy_until = c + 2;
                end else begin
                    exp_q.push_back({8'h00, mread(wb_adr)});
                    e_ack[c+3] = 2;
                    busy_until = c + 3;
                end
            end else if (vg) begin
                e_slot[c+1] = vid_adr;
                e_vdat[c+2] = mread(vid_adr);
            end
            e_slot.delete(c); e_we.delete(c); e_d.delete(c); e_vdat.delete(c); e_ack.delete(c);
        end
        cyc++;
    end

    // Driver: per-cycle history; video address advances on each grant, CPU drops after ack.
    bit          gh [64];
    bit          ah [64];
    bit          vh [64];
    bit          wh [64];
    logic [13:0] rah [64];
    logic [15:0] ack_dat;
    logic [13:0] vid_stop = 14'h3FFF;

    task automatic run(input int n);
        bit g, a;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g = vid_gnt; a = wb_ack;
            gh[i] = g; ah[i] = a; vh[i] = vid_valid; wh[i] = ram_we; rah[i] = ram_adr;
            if (a) ack_dat = wb_dat_o;
            @(posedge clk); #1;
            if (g) begin
                vid_adr = vid_adr + 14'd1;
                if (vid_adr == vid_stop) vid_req = 1'b0;
            end
            if (a) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
        end
    endtask

    task automatic cpu_start(input bit we, input logic [13:0] a, input logic [7:0] d,
                             input logic [1:0] sel);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = a; wb_dat = {8'hEE, d}; wb_sel = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(2);

        // write 0x5A to 0x0123 then read it back, video idle
        cpu_start(1'b1, 14'h0123, 8'h5A, 2'b01);
        run(6);
        chk("t_wr_we_n1", wh[1], 1);
        chk("t_wr_adr_n1", rah[1], 14'h0123);
        chk("t_wr_ack_n1", ah[1], 0);
        chk("t_wr_ack_n2", ah[2], 1);
        chk("t_wr_ack_n3", ah[3], 0);
        cpu_start(1'b0, 14'h0123, 8'h00, 2'b01);
        run(6);
        chk("t_rd_ack_n2", ah[2], 0);
        chk("t_rd_ack_n3", ah[3], 1);
        chk("t_rd_data", ack_dat, 16'h005A);

        // ten back-to-back video fetches
        vid_adr = 14'h0000; vid_stop = 14'd10; vid_req = 1'b1;
        run(14);
        for (int i = 0; i < 14; i++) begin
            chk("t_vid_gnt", gh[i], (i < 10));
            chk("t_vid_valid", vh[i], (i >= 2 && i < 12));
        end
        vid_stop = 14'h3FFF;

        // continuous video with a pending CPU read
        vid_adr = 14'h0040; vid_req = 1'b1;
        cpu_start(1'b0, 14'h0123, 8'h00, 2'b01);
`ifdef KGD_ARB_STARVE_EN
        run(16);
        for (int i = 0; i < 16; i++) begin
            chk("t_starve_gnt", gh[i], (i != BURST));
            chk("t_starve_ack", ah[i], (i == BURST + 3));
        end
        chk("t_starve_data", ack_dat, 16'h005A);
        vid_req = 1'b0;
`else
        run(10);
        for (int i = 0; i < 10; i++) begin
            chk("t_prio_gnt", gh[i], 1);
            chk("t_prio_ack", ah[i], 0);
        end
        vid_req = 1'b0;
        run(5);
        chk("t_prio_ack_n3", ah[3], 1);
        chk("t_prio_ack_n2", ah[2], 0);
        chk("t_prio_data", ack_dat, 16'h005A);
`endif
        run(3);

        // write with sel=10: acknowledged, no RAM write
        cpu_start(1'b1, 14'h0200, 8'h77, 2'b10);
        run(5);
        chk("t_sel_ack_n2", ah[2], 1);
        for (int i = 0; i < 5; i++) chk("t_sel_no_we", wh[i], 0);
        chk("t_sel_fixture", fx_rd(14'h0200), 8'h3E);
        cpu_start(1'b0, 14'h0200, 8'h00, 2'b01);
        run(6);
        chk("t_sel_rd_ack", ah[3], 1);
        chk("t_sel_rd_data", ack_dat, 16'h003E);

        // cycle dropped after the grant: write still completes and acks
        cpu_start(1'b1, 14'h0300, 8'h11, 2'b01);
        run(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        run(4);
        chk("t_drop_ack", ah[1], 1);
        chk("t_drop_fixture", fx_rd(14'h0300), 8'h11);
        cpu_start(1'b0, 14'h0300, 8'h00, 2'b01);
        run(6);
        chk("t_drop_rd_data", ack_dat, 16'h0011);

        // reset during WAIT of a read
        cpu_start(1'b0, 14'h0123, 8'h00, 2'b01);
        run(2);
        chk("t_rst_in_wait", cpu_state, 2'd2);
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        run(3);
        for (int i = 0; i < 3; i++) chk("t_rst_no_ack", ah[i], 0);
        rst_n = 1'b1;
        run(2);
        for (int i = 0; i < 2; i++) chk("t_rst_no_ack_after", ah[i], 0);
        chk("t_rst_idle", cpu_state, 2'd0);
        cpu_start(1'b0, 14'h0123, 8'h00, 2'b01);
        run(6);
        chk("t_rst_rd_ack", ah[3], 1);
        chk("t_rst_rd_data", ack_dat, 16'h005A);

        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
